// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states and word width.
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_STACK  = 2'b10;
  localparam logic [1:0] PC_SRC_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_EXEC  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus plus the instruction handoff to decode.
interface fetch_unit_if;

  logic                       imem_req;
  logic [cpu_pkg::WORD_W-1:0] imem_addr;
  logic [cpu_pkg::WORD_W-1:0] imem_rdata;
  logic                       imem_ack;
  logic [cpu_pkg::WORD_W-1:0] ir_out;
  logic                       ir_valid;
  logic                       ir_ready;

  modport master (
    output imem_req, imem_addr, ir_out, ir_valid,
    input  imem_rdata, imem_ack, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_out, ir_valid,
    output imem_rdata, imem_ack, ir_ready
  );

endinterface

// File: rtl/fetch_unit_pc_select.sv
// Combinational 4:1 next-PC mux; returns the word-aligned PC and flags dropped low bits.
module pc_select
  import cpu_pkg::*;
(
  input  logic [1:0]        pc_src,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] pc_plus4,
  input  logic [WORD_W-1:0] target_pc,
  input  logic [WORD_W-1:0] stack_pc,
  output logic [WORD_W-1:0] next_pc,
  output logic              misalign
);

  logic [WORD_W-1:0] sel;

  always_comb begin
    sel = pc;
    case (pc_src)
      PC_SRC_SEQ:    sel = pc_plus4;
      PC_SRC_TARGET: sel = target_pc;
      PC_SRC_STACK:  sel = stack_pc;
      PC_SRC_HOLD:   sel = pc;
      default:       sel = pc;
    endcase
  end

  assign next_pc  = {sel[WORD_W-1:2], 2'b00};
  assign misalign = |sel[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack and hands the word to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      bus,
  input  logic [1:0]        pc_src,
  input  logic [WORD_W-1:0] target_pc,
  input  logic [WORD_W-1:0] stack_pc,
  input  logic              pc_write,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              misalign,
  output logic              fetch_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  fetch_state_e      state, state_nxt;
  logic [WORD_W-1:0] pc, stale_addr, ir_q, sel_pc;
  logic              ir_vld, drop, misalign_q, fetch_err_q, sel_misalign;
  logic [TO_W-1:0]   to_cnt;
  logic              redirect_act, commit;

  assign redirect_act = redirect && (state != ST_IDLE);
  assign commit       = pc_write && !redirect && (state == ST_EXEC);
  assign pc_plus4     = pc + 32'd4;
  assign pc_out       = pc;
  assign misalign     = misalign_q;
  assign fetch_err    = fetch_err_q;
  assign bus.ir_out   = ir_q;
  assign bus.ir_valid = ir_vld;

  pc_select u_pc_select (
    .pc_src    (pc_src),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .target_pc (target_pc),
    .stack_pc  (stack_pc),
    .next_pc   (sel_pc),
    .misalign  (sel_misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (bus.imem_ack && !drop && !redirect) state_nxt = ST_HOLD;
      ST_HOLD:  if (redirect) state_nxt = ST_FETCH;
                else if (bus.ir_ready) state_nxt = ST_EXEC;
      ST_EXEC:  if (redirect || pc_write) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // While a redirected fetch is still outstanding, keep presenting its original address.
  always_comb begin
    bus.imem_req  = (state == ST_FETCH);
    bus.imem_addr = drop ? stale_addr : pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      ir_q        <= '0;
      ir_vld      <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      to_cnt      <= '0;
      drop        <= 1'b0;
    end else begin
      if (redirect_act) begin
        pc     <= {redirect_pc[WORD_W-1:2], 2'b00};
        ir_vld <= 1'b0;
        if (|redirect_pc[1:0]) misalign_q <= 1'b1;
      end else if (commit) begin
        pc <= sel_pc;
        if (sel_misalign) misalign_q <= 1'b1;
      end

      if (state == ST_FETCH) begin
        if (bus.imem_ack) begin
          to_cnt <= '0;
          drop   <= 1'b0;
          if (!drop && !redirect) begin
            ir_q   <= bus.imem_rdata;
            ir_vld <= 1'b1;
          end
        end else begin
          if (redirect && !drop) begin
            drop       <= 1'b1;
            stale_addr <= pc;
          end
          // Timeout only flags the error; the request keeps retrying.
          if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            fetch_err_q <= 1'b1;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
      end

      if ((state == ST_HOLD) && bus.ir_ready && !redirect) ir_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level PC/flag model.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        pc_src;
  logic [31:0]       target_pc, stack_pc, redirect_pc;
  logic              pc_write, redirect;
  logic [31:0]       pc_out, pc_plus4;
  logic              misalign, fetch_err;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .pc_src      (pc_src),
    .target_pc   (target_pc),
    .stack_pc    (stack_pc),
    .pc_write    (pc_write),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .misalign    (misalign),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic        m_mis, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick(input logic [1:0] src, input logic [31:0] cur,
                                       input logic [31:0] tgt, input logic [31:0] stk);
    case (src)
      2'd0:    return cur + 32'd4;
      2'd1:    return tgt;
      2'd2:    return stk;
      default: return cur;
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic fetch_done(input int lat, input logic [31:0] data);
    for (int i = 0; i < lat; i++) begin
      check("req_wait", bus.imem_req, 1);
      check("addr_wait", bus.imem_addr, m_pc);
      pc_write  = 1'($urandom_range(0, 1));
      pc_src    = 2'($urandom_range(0, 3));
      target_pc = $urandom;
      stack_pc  = $urandom;
      tick();
      pc_write = 1'b0;
      check("pc_ignore_fetch", pc_out, m_pc);
      check("ir_valid_fetch", bus.ir_valid, 0);
    end
    check("addr_ack", bus.imem_addr, m_pc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    check("ir_valid_ack", bus.ir_valid, 1);
    check("ir_out_ack", bus.ir_out, data);
    check("req_drop", bus.imem_req, 0);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("fetch_err", fetch_err, m_err);
  endtask

  task automatic consume(input int dly, input logic [31:0] data);
    for (int i = 0; i < dly; i++) begin
      pc_write = 1'($urandom_range(0, 1));
      tick();
      pc_write = 1'b0;
      check("ir_valid_hold", bus.ir_valid, 1);
      check("pc_ignore_hold", pc_out, m_pc);
    end
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    check("ir_valid_taken", bus.ir_valid, 0);
    check("ir_out_kept", bus.ir_out, data);
  endtask

  task automatic exec_wait(input int dly);
    for (int i = 0; i < dly; i++) begin
      bus.ir_ready = 1'($urandom_range(0, 1));
      tick();
      check("pc_exec", pc_out, m_pc);
      check("req_exec", bus.imem_req, 0);
      check("ir_valid_exec", bus.ir_valid, 0);
    end
    bus.ir_ready = 1'b0;
  endtask

  task automatic commit(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] stk);
    logic [31:0] sel;
    pc_src    = src;
    target_pc = tgt;
    stack_pc  = stk;
    pc_write  = 1'b1;
    tick();
    pc_write = 1'b0;
    sel  = pick(src, m_pc, tgt, stk);
    m_pc = {sel[31:2], 2'b00};
    if (sel[1:0] != 2'b00) m_mis = 1'b1;
    check("pc_commit", pc_out, m_pc);
    check("misalign", misalign, m_mis);
    check("req_commit", bus.imem_req, 1);
    check("addr_commit", bus.imem_addr, m_pc);
  endtask

  task automatic instr(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] stk);
    logic [31:0] d;
    d = $urandom;
    fetch_done($urandom_range(0, 3), d);
    consume($urandom_range(0, 2), d);
    exec_wait($urandom_range(0, 2));
    commit(src, tgt, stk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] old, ra, d;
    rst_n = 1'b0; pc_src = 2'd0; target_pc = '0; stack_pc = '0; pc_write = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.ir_ready = 1'b0;
    m_pc = 32'h0; m_mis = 1'b0; m_err = 1'b0;

    repeat (3) tick();
    check("rst_req", bus.imem_req, 0);
    check("rst_ir_valid", bus.ir_valid, 0);
    check("rst_ir_out", bus.ir_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_misalign", misalign, 0);
    check("rst_fetch_err", fetch_err, 0);

    rst_n = 1'b1;
    tick();
    check("req_rise", bus.imem_req, 1);
    check("addr_first", bus.imem_addr, 0);
    fetch_done(1, 32'hA5A5_0001);
    check("first_ir", bus.ir_out, 32'hA5A5_0001);
    check("first_plus4", pc_plus4, 32'd4);
    consume(0, 32'hA5A5_0001);
    exec_wait(1);

    commit(2'd0, 32'h0, 32'h0);
    check("seq_addr", bus.imem_addr, 32'h4);
    instr(2'd1, 32'h100, 32'h0);
    check("target_addr", bus.imem_addr, 32'h100);
    instr(2'd2, 32'h0, 32'h8);
    check("stack_addr", bus.imem_addr, 32'h8);
    instr(2'd3, $urandom, $urandom);
    check("hold_addr", bus.imem_addr, 32'h8);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        old = m_pc;
        ra  = rand_addr();
        redirect = 1'b1; redirect_pc = ra;
        tick();
        redirect = 1'b0;
        m_pc = {ra[31:2], 2'b00};
        if (ra[1:0] != 2'b00) m_mis = 1'b1;
        check("rd_pc", pc_out, m_pc);
        check("rd_stale_addr", bus.imem_addr, old);
        check("rd_req", bus.imem_req, 1);
        check("rd_misalign", misalign, m_mis);
        repeat ($urandom_range(0, 3)) begin
          tick();
          check("rd_stale_hold", bus.imem_addr, old);
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = $urandom;
        tick();
        bus.imem_ack = 1'b0;
        check("rd_discard", bus.ir_valid, 0);
        check("rd_new_addr", bus.imem_addr, m_pc);
      end
      instr(2'($urandom_range(0, 3)), rand_addr(), rand_addr());
    end

    instr(2'd1, 32'h103, 32'h0);
    check("mis_pc", pc_out, 32'h100);
    check("mis_set", misalign, 1);
    m_mis = 1'b1;

    instr(2'd1, 32'h10, 32'h0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    m_pc = 32'h40;
    check("redir_addr_held", bus.imem_addr, 32'h10);
    repeat (2) begin
      tick();
      check("redir_req_held", bus.imem_req, 1);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    check("stale_dropped", bus.ir_valid, 0);
    check("redir_new_addr", bus.imem_addr, 32'h40);
    fetch_done(1, 32'h1234_5678);
    consume(0, 32'h1234_5678);
    commit(2'd0, 32'h0, 32'h0);

    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_0BAD;
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    bus.imem_ack = 1'b0; redirect = 1'b0;
    m_pc = 32'h200;
    check("coinc_valid", bus.ir_valid, 0);
    check("coinc_req", bus.imem_req, 1);
    check("coinc_addr", bus.imem_addr, 32'h200);
    d = $urandom;
    fetch_done(0, d);
    consume(0, d);
    commit(2'd0, 32'h0, 32'h0);

    for (int i = 1; i < 16; i++) begin
      tick();
      check("to_not_yet", fetch_err, 0);
    end
    tick();
    m_err = 1'b1;
    check("to_err", fetch_err, 1);
    check("to_req", bus.imem_req, 1);
    check("to_addr", bus.imem_addr, m_pc);
    fetch_done(2, 32'hC0DE_0001);
    consume(0, 32'hC0DE_0001);

    commit(2'd1, 32'hFFFF_FFFC, 32'h0);
    check("wrap_plus4", pc_plus4, 32'h0);
    instr(2'd0, 32'h0, 32'h0);
    check("wrap_pc", pc_out, 32'h0);

    tick();
    rst_n = 1'b0;
    tick();
    m_pc = 32'h0; m_mis = 1'b0; m_err = 1'b0;
    check("mrst_req", bus.imem_req, 0);
    check("mrst_valid", bus.ir_valid, 0);
    check("mrst_pc", pc_out, 32'h0);
    check("mrst_mis", misalign, 0);
    check("mrst_err", fetch_err, 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h5555_AAAA;
    tick();
    check("mrst_stray", bus.ir_valid, 0);
    check("mrst_out", bus.ir_out, 32'h0);
    rst_n = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check("mrst_late_ack", bus.ir_valid, 0);
    check("mrst_refetch", bus.imem_req, 1);
    check("mrst_addr", bus.imem_addr, 32'h0);
    fetch_done(1, 32'h7777_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IR/decode and control unit of the multi-cycle CPU.
- Owns the architectural PC register and selects the next PC from sequential, branch/jump target and return-stack sources.
- Fetches each instruction from instruction memory over a req/ack handshake and presents it to decode over a valid/ready handshake.
- Exports pc and pc+4 for the target adder and the return-address stack.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset (word aligned)
TIMEOUT, 16, max cycles imem_req may wait for imem_ack before fetch_err
TO_W, $clog2(TIMEOUT+1), width of timeout counter (derived, do not override)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
pc_src  in  2  next-PC select: 00 pc+4, 01 target_pc, 10 stack_pc, 11 hold (refetch same pc)
target_pc  in  32  branch/jump target from PC adder
stack_pc  in  32  return address from stack
pc_write  in  1  control unit end-of-instruction pulse; commit next PC
redirect  in  1  abort current fetch, restart at redirect_pc
redirect_pc  in  32  restart address
imem_req  out  1  fetch request, held until ack
imem_addr  out  32  fetch address (= pc)
imem_rdata  in  32  instruction word, valid with imem_ack
imem_ack  in  1  single-cycle response pulse
ir_out  out  32  latched instruction to decode
ir_valid  out  1  ir_out holds an unconsumed instruction
ir_ready  in  1  decode accepts ir_out
pc_out  out  32  current pc
pc_plus4  out  32  pc + 4 (stack push data, PC-relative base)
misalign  out  1  sticky: a committed next PC had bits[1:0] != 0
fetch_err  out  1  sticky: ack timeout occurred

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, state=IDLE, imem_req=0, ir_out=0, ir_valid=0, misalign=0, fetch_err=0, timeout count=0, drop=0. Reset mid-handshake abandons it; a late ack after reset is ignored (drop is cleared, state IDLE).
- States: IDLE, FETCH, HOLD, EXEC.
- IDLE: next cycle -> FETCH. Entered only from reset.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack. The counter increments each cycle without ack.
  - On ack with drop=0: ir_out<=imem_rdata, ir_valid<=1, -> HOLD. Fetch latency from req rise is 1 + memory wait cycles.
  - Counter reaching TIMEOUT: fetch_err<=1, counter clears, request stays asserted (retry continues).
- HOLD: ir_valid=1. When ir_ready=1: ir_valid<=0 and -> EXEC. ir_out holds its value until the next fetch completes.
- EXEC: waits for pc_write.
  - On pc_write: pc <= {sel[31:2], 2'b00}, where sel comes from pc_src. misalign<=1 if sel[1:0]!=0. -> FETCH.
  - pc_src=11 reloads the same pc.
  - pc_write in IDLE, FETCH or HOLD is ignored.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). pc_plus4 is combinational from pc.
- redirect (priority over pc_write, any non-IDLE state):
  - pc <= {redirect_pc[31:2], 2'b00} and ir_valid<=0.
  - If in FETCH with no ack the same cycle: drop<=1, stay in FETCH with req held.
  - Once the stale ack arrives: drop<=0 and the ack is discarded. req stays 1 and a new fetch starts at the new pc.
  - If ack coincides with redirect: discard the data, no drop needed, refetch next cycle.
  - From HOLD or EXEC: -> FETCH. The same misalign rule applies.
- ir_ready is ignored when ir_valid=0.
- imem_addr changes only while imem_req=0, or in the cycle after an ack.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_SRC_* encodings (00/01/10/11), shared with the control unit and the pc mux select;
  - fetch state enum (IDLE, FETCH, HOLD, EXEC);
  - WORD_W=32.
- One natural sub-module: pc_select, a combinational 4:1 next-PC mux with alignment check. It is reused by the control unit for target validation. Everything else stays flat in fetch_unit.

Test Plan:
- Reset then idle memory with 2-cycle ack latency, imem_rdata=32'hA5A5_0001 -> imem_req rises 1 cycle after reset release, imem_addr=0, ir_valid=1 with ir_out=32'hA5A5_0001 on the cycle after ack; pc_plus4=4.
- Consume with ir_ready=1, then pc_write with pc_src=00, then 01 (target_pc=32'h100), then 10 (stack_pc=32'h8) -> successive imem_addr 4, 32'h100, 32'h8; pc_src=11 refetches 32'h8.
- target_pc=32'h103 with pc_src=01 -> pc=32'h100, misalign=1 and stays set until reset.
- Redirect to 32'h40 while a fetch at 32'h10 is outstanding, stale ack 3 cycles later with 32'hDEAD_BEEF -> ir_valid stays 0 for that ack, next request at 32'h40, its data is latched.
- Withhold ack for 16 cycles -> fetch_err=1 at cycle 16, req still asserted; a later ack completes normally. pc=32'hFFFF_FFFC gives pc_plus4=0.
- Assert rst_n=0 during FETCH -> next cycle imem_req=0, ir_valid=0, pc=RESET_PC; a stray ack during reset has no effect.
